ili_bus_ctrl: RTL and testbench
===============================

# ili_bus_ctrl

- Avalon-MM slave that sequences the 8080-style parallel write bus of the ILI9341 2.4" TFT in hardware.
- Replaces software bit-banging of CS_n/RS/WR_n through single-bit PIO ports.
- The CPU pushes command and data words into an internal FIFO; an FSM drains each entry as one write strobe with programmable low and high widths.
- Sits between the Nios II data master (via the interconnect) and the TFT pins.

## Interface
Parameters:
- FIFO_DEPTH, 16: entries in the command/data FIFO; power of two, ≥2.
- DATA_W, 16: LCD data bus width.
- TLOW_RST, 1: reset value of the WR_n-low extension field.
- THIGH_RST, 1: reset value of the WR_n-high extension field.

Ports:
- clk  in  1  system clock; the only clock.
- reset_n  in  1  asynchronous, active-low reset.
- address  in  2  register select.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- readdata  out  32  read data; combinational mux, zero wait states.
- lcd_cs_n  out  1  panel chip select.
- lcd_rs  out  1  0 = command, 1 = data.
- lcd_wr_n  out  1  write strobe.
- lcd_rd_n  out  1  held at 1; reads are unsupported.
- lcd_data  out  DATA_W  panel data bus.

## Operation
- A write is accepted when chipselect && !write_n.
- Address 0, write: push {rs=0, writedata[DATA_W-1:0]} (command).
- Address 1, write: push {rs=1, writedata[DATA_W-1:0]} (data).
- Address 0 and 1, read: 0.
- Address 2, status/control register.
  - Read bits: 0 busy (FSM not IDLE or FIFO non-empty), 1 full, 2 empty, 3 overflow (sticky), 4 lcd_rst_n (when the macro is enabled, else 0), [15:8] FIFO count.
  - Write: bit 3 = 1 clears overflow; bit 4 drives lcd_rst_n (when the macro is enabled).
- Address 3, timing register, read/write.
  - [3:0] TLOW: WR_n is low for TLOW+1 cycles.
  - [7:4] THIGH: WR_n is high for THIGH+1 cycles.
- Push to a full FIFO: the word is dropped and overflow is set. The full test uses the count at the start of the cycle.
- A push and a pop may occur in the same cycle; the count is then unchanged.
- FSM states:
  - IDLE: cs_n=1, wr_n=1. If the FIFO is non-empty → SETUP.
  - SETUP (1 cycle): pop the head entry; drive lcd_data and lcd_rs; cs_n=0; latch TLOW/THIGH into the counters. → WR_LOW.
  - WR_LOW: wr_n=0 for TLOW+1 cycles. → WR_HIGH.
  - WR_HIGH: wr_n=1 for THIGH+1 cycles; data and rs are held. At the end: FIFO non-empty → SETUP with cs_n kept low; otherwise → IDLE.
- Timing register writes during a transfer take effect at the next SETUP.
- Reset values:
  - lcd_cs_n=1, lcd_wr_n=1, lcd_rd_n=1, lcd_rs=1, lcd_data=0.
  - FIFO empty, overflow=0, TLOW=TLOW_RST, THIGH=THIGH_RST.
  - FSM in IDLE.
- Reset asserted mid-transfer: all outputs return to their reset values immediately (asynchronously) and the FIFO contents are discarded.

## Timing
- The entry accepted at edge k is visible on the pins after edge k+1, i.e. during SETUP: cs_n low, data and rs valid.
- wr_n falls after edge k+2.
- Each transfer takes 1 + (TLOW+1) + (THIGH+1) cycles. At the defaults this is 5 cycles: 100 ns at 50 MHz, with WR_n low for 40 ns.
- Data is stable from SETUP until the end of WR_HIGH, giving ≥1 cycle of setup before the falling edge of wr_n and ≥THIGH+1 cycles of hold after its rising edge.
- For back-to-back entries, cs_n does not deassert between words.
- Status bits reflect registered state; there is no read side effect.

## Configuration
- ILI_BUS_CTRL_RESET_PIN_EN defined:
  - Adds output port lcd_rst_n (1 bit) with reset value 0, i.e. the panel is held in reset.
  - lcd_rst_n is software-driven through address 2 bit 4 and readable back on the same bit.
- Undefined: no lcd_rst_n port; address 2 bit 4 reads 0 and writes to it are ignored.

## Structure
- Shared package ili_pkg holds:
  - register address constants (ADDR_CMD, ADDR_DATA, ADDR_CTRL, ADDR_TIMING);
  - status bit indices;
  - the FSM state enum (IDLE, SETUP, WR_LOW, WR_HIGH);
  - the FIFO entry type {rs, data}.
- One sub-module: ili_sync_fifo, a single-clock FIFO with the same clk/reset_n that exposes count, full and empty. The top level holds the register file and the FSM.

## Test plan
- After reset: pins read cs_n=1, wr_n=1, rd_n=1, rs=1, data=0; status reads empty=1, busy=0; timing reads 0x11.
- Write 0x2C to address 0: one strobe with rs=0, data=0x002C; wr_n low for exactly 2 cycles and high for 2; cs_n low for 5 cycles, then back to 1.
- Write 0x002C to address 0, then 0xF800 to address 1 and 0x07E0 to address 1 back to back: three strobes in order with rs=0,1,1; cs_n stays low throughout; the pin activity totals 15 cycles.
- Write timing 0x32, then one data word: wr_n low 3 cycles, high 4 cycles. Change timing mid-transfer: the current strobe is unaffected.
- Push FIFO_DEPTH+3 words while the FSM is stalled behind a long timing setting (0xFF): overflow=1, count reaches FIFO_DEPTH, and only FIFO_DEPTH strobes occur. Write 0x8 to address 2: overflow clears.
- Assert reset_n during WR_LOW: wr_n and cs_n go to 1 immediately. After release, empty=1 and no further strobes occur. With ILI_BUS_CTRL_RESET_PIN_EN defined, lcd_rst_n=0 until 0x10 is written to address 2.

Source files
------------

// File: rtl/ili_pkg.sv
// Shared definitions for the ILI9341 8080-bus write sequencer:
// register map, status bit positions, FSM states and FIFO entry view.
package ili_pkg;

  localparam logic [1:0] ADDR_CMD    = 2'd0;
  localparam logic [1:0] ADDR_DATA   = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;
  localparam logic [1:0] ADDR_TIMING = 2'd3;

  localparam int ST_BUSY    = 0;
  localparam int ST_FULL    = 1;
  localparam int ST_EMPTY   = 2;
  localparam int ST_OVF     = 3;
  localparam int ST_RST     = 4;
  localparam int ST_CNT_LSB = 8;

  localparam int MAX_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    WR_LOW,
    WR_HIGH
  } ili_state_e;

  typedef struct packed {
    logic                  rs;
    logic [MAX_DATA_W-1:0] data;
  } ili_entry_t;

endpackage

// File: rtl/ili_bus_ctrl_if.sv
// Avalon-MM slave bundle for ili_bus_ctrl.
// address/chipselect/write_n/writedata in, readdata out (zero wait).
interface ili_bus_ctrl_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/ili_sync_fifo.sv
// Single-clock show-ahead FIFO; push to full is ignored by this block.
// Ports: clk, reset_n, push/wdata, pop/rdata, count, full, empty.
module ili_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 17
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push,
  input  logic [W-1:0]           wdata,
  input  logic                   pop,
  output logic [W-1:0]           rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/ili_bus_ctrl.sv
// Avalon-MM slave sequencing ILI9341 8080 write strobes from a FIFO.
// Ports: clk, reset_n, avs (bus), lcd_cs_n/rs/wr_n/rd_n/data pins;
// lcd_rst_n exists only with ILI_BUS_CTRL_RESET_PIN_EN defined.
module ili_bus_ctrl
  import ili_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int DATA_W     = 16,
  parameter int TLOW_RST   = 1,
  parameter int THIGH_RST  = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  ili_bus_ctrl_if.slave     avs,
  output logic              lcd_cs_n,
  output logic              lcd_rs,
  output logic              lcd_wr_n,
  output logic              lcd_rd_n,
  output logic [DATA_W-1:0] lcd_data
`ifdef ILI_BUS_CTRL_RESET_PIN_EN
  ,
  output logic              lcd_rst_n
`endif
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  ili_state_e        state, next_state;
  logic              wr_en, push, pop;
  logic              ctrl_wr, tim_wr;
  logic [DATA_W:0]   fifo_wd, fifo_rd;
  logic [CW-1:0]     fifo_cnt;
  logic              fifo_full, fifo_empty;
  ili_entry_t        head;
  logic [3:0]        tlow_q, thigh_q;
  logic [3:0]        cnt_q, hi_q;
  logic              rs_q;
  logic [DATA_W-1:0] data_q;
  logic              ovf_q;
  logic              rst_pin;
  logic              busy;
  logic              unused_bits;

  assign wr_en   = avs.chipselect && !avs.write_n;
  assign push    = wr_en &&
                   (avs.address == ADDR_CMD ||
                    avs.address == ADDR_DATA);
  assign ctrl_wr = wr_en && (avs.address == ADDR_CTRL);
  assign tim_wr  = wr_en && (avs.address == ADDR_TIMING);
  assign fifo_wd = {avs.address == ADDR_DATA,
                    avs.writedata[DATA_W-1:0]};

  ili_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (DATA_W + 1)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .wdata   (fifo_wd),
    .pop     (pop),
    .rdata   (fifo_rd),
    .count   (fifo_cnt),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_comb begin
    head                   = '0;
    head.rs                = fifo_rd[DATA_W];
    head.data[DATA_W-1:0]  = fifo_rd[DATA_W-1:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (!fifo_empty) next_state = SETUP;
      SETUP:   next_state = WR_LOW;
      WR_LOW:  if (cnt_q == '0) next_state = WR_HIGH;
      WR_HIGH: begin
        if (cnt_q == '0)
          next_state = fifo_empty ? IDLE : SETUP;
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    lcd_cs_n = (state == IDLE);
    lcd_wr_n = (state != WR_LOW);
    lcd_rd_n = 1'b1;
    lcd_rs   = rs_q;
    lcd_data = data_q;
    pop      = (state == SETUP);
    busy     = (state != IDLE) || !fifo_empty;
  end

  // The head is captured on the edge that enters SETUP so the
  // pins carry valid data for the whole SETUP cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rs_q   <= 1'b1;
      data_q <= '0;
      cnt_q  <= '0;
      hi_q   <= '0;
    end else begin
      if (next_state == SETUP) begin
        rs_q   <= head.rs;
        data_q <= head.data[DATA_W-1:0];
      end
      unique case (state)
        SETUP: begin
          cnt_q <= tlow_q;
          hi_q  <= thigh_q;
        end
        WR_LOW:  cnt_q <= (cnt_q == '0) ? hi_q : cnt_q - 1'b1;
        WR_HIGH: if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tlow_q  <= 4'(TLOW_RST);
      thigh_q <= 4'(THIGH_RST);
      ovf_q   <= 1'b0;
    end else begin
      if (tim_wr) begin
        tlow_q  <= avs.writedata[3:0];
        thigh_q <= avs.writedata[7:4];
      end
      if (push && fifo_full)
        ovf_q <= 1'b1;
      else if (ctrl_wr && avs.writedata[ST_OVF])
        ovf_q <= 1'b0;
    end
  end

`ifdef ILI_BUS_CTRL_RESET_PIN_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     rst_pin <= 1'b0;
    else if (ctrl_wr) rst_pin <= avs.writedata[ST_RST];
  end
  assign lcd_rst_n = rst_pin;
`else
  assign rst_pin = 1'b0;
`endif

  always_comb begin
    avs.readdata = '0;
    unique case (avs.address)
      ADDR_CTRL: begin
        avs.readdata[ST_BUSY]          = busy;
        avs.readdata[ST_FULL]          = fifo_full;
        avs.readdata[ST_EMPTY]         = fifo_empty;
        avs.readdata[ST_OVF]           = ovf_q;
        avs.readdata[ST_RST]           = rst_pin;
        avs.readdata[ST_CNT_LSB +: 8]  = 8'(fifo_cnt);
      end
      ADDR_TIMING: avs.readdata[7:0] = {thigh_q, tlow_q};
      default:     avs.readdata = '0;
    endcase
  end

  assign unused_bits = &{1'b0, avs.writedata, head};
endmodule

// File: tb/tb_ili_bus_ctrl.sv
// Self-checking bench for ili_bus_ctrl: directed and random pushes,
// pin trace decoded into strobes and compared with expected words.
module tb_ili_bus_ctrl;
  localparam int D = 16;

  typedef struct packed {
    logic        cs_n;
    logic        wr_n;
    logic        rs;
    logic [15:0] data;
  } samp_t;

  typedef struct {
    logic        rs;
    logic [15:0] data;
    int          low;
    int          gap;
    int          pre;
    bit          followed;
    bit          stable;
  } strobe_t;

  typedef struct {
    logic        rs;
    logic [15:0] data;
    int          tl;
    int          th;
  } exp_t;

  logic        clk;
  logic        reset_n;
  logic        lcd_cs_n, lcd_rs, lcd_wr_n, lcd_rd_n;
  logic [15:0] lcd_data;
`ifdef ILI_BUS_CTRL_RESET_PIN_EN
  logic        lcd_rst_n;
`endif

  int checks;
  int failures;
  bit rec;

  samp_t   trace[$];
  strobe_t got[$];
  exp_t    exp_q[$];

  ili_bus_ctrl_if bus ();

  ili_bus_ctrl #(
    .FIFO_DEPTH (D),
    .DATA_W     (16),
    .TLOW_RST   (1),
    .THIGH_RST  (1)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .avs       (bus),
    .lcd_cs_n  (lcd_cs_n),
    .lcd_rs    (lcd_rs),
    .lcd_wr_n  (lcd_wr_n),
    .lcd_rd_n  (lcd_rd_n),
    .lcd_data  (lcd_data)
`ifdef ILI_BUS_CTRL_RESET_PIN_EN
    ,
    .lcd_rst_n (lcd_rst_n)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rec) trace.push_back({lcd_cs_n, lcd_wr_n, lcd_rs, lcd_data});
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.address    = a;
    bus.writedata  = d;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    @(posedge clk);
    #1;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.address    = a;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b1;
    #1;
    d = bus.readdata;
    bus.chipselect = 1'b0;
  endtask

  task automatic push(input bit rs, input logic [15:0] d,
                      input int tl, input int th, input bit keep);
    exp_t e;
    wr(rs ? 2'd1 : 2'd0, {16'h0, d});
    if (keep) begin
      e.rs = rs; e.data = d; e.tl = tl; e.th = th;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_idle(input string tag, input int maxc);
    logic [31:0] s;
    int n;
    n = 0;
    do begin
      rd(2'd2, s);
      n++;
    end while (s[0] && n < maxc);
    chk({tag, "_idle"}, s[0], 1'b0);
  endtask

  task automatic wait_wr_low(input string tag, input int maxc);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (lcd_wr_n !== 1'b0 && n < maxc);
    chk({tag, "_wrlow_seen"}, lcd_wr_n, 1'b0);
  endtask

  task automatic analyze();
    int n;
    n = trace.size();
    got.delete();
    for (int i = 0; i < n; i++) begin
      if (trace[i].cs_n == 1'b0 && trace[i].wr_n == 1'b0 &&
          (i == 0 || trace[i-1].wr_n == 1'b1)) begin
        strobe_t s;
        int j, k, hend;
        s.rs     = trace[i].rs;
        s.data   = trace[i].data;
        s.stable = (i > 0) && trace[i-1].cs_n == 1'b0 &&
                   trace[i-1].rs == s.rs && trace[i-1].data == s.data;
        s.pre = 0;
        j = i - 1;
        while (j >= 0 && trace[j].cs_n == 1'b0 && trace[j].wr_n == 1'b1) begin
          s.pre++;
          j--;
        end
        j = i;
        while (j < n && trace[j].wr_n == 1'b0) begin
          if (trace[j].rs != s.rs || trace[j].data != s.data) s.stable = 0;
          j++;
        end
        s.low = j - i;
        k = j;
        while (k < n && trace[k].wr_n == 1'b1 && trace[k].cs_n == 1'b0) k++;
        s.gap      = k - j;
        s.followed = (k < n) && trace[k].wr_n == 1'b0;
        hend = s.followed ? k - 1 : k;
        for (int m = j; m < hend; m++)
          if (trace[m].rs != s.rs || trace[m].data != s.data) s.stable = 0;
        got.push_back(s);
        i = j - 1;
      end
    end
  endtask

  task automatic check_strobes(input string tag);
    int m;
    analyze();
    chk({tag, "_nstrobes"}, got.size(), exp_q.size());
    m = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    for (int i = 0; i < m; i++) begin
      string t;
      t = $sformatf("%s_s%0d", tag, i);
      chk({t, "_rs"},     got[i].rs,     exp_q[i].rs);
      chk({t, "_data"},   got[i].data,   exp_q[i].data);
      chk({t, "_low"},    got[i].low,    exp_q[i].tl + 1);
      chk({t, "_high"},   got[i].gap,
          exp_q[i].th + 1 + (got[i].followed ? 1 : 0));
      chk({t, "_stable"}, got[i].stable, 1'b1);
      if (i == 0 || !got[i-1].followed)
        chk({t, "_setup"}, got[i].pre, 1);
    end
    exp_q.delete();
    trace.delete();
  endtask

  function automatic int cs_low_count();
    int c;
    c = 0;
    foreach (trace[i]) if (trace[i].cs_n == 1'b0) c++;
    return c;
  endfunction

  function automatic int cs_falls();
    int c;
    c = 0;
    for (int i = 1; i < trace.size(); i++)
      if (trace[i-1].cs_n == 1'b1 && trace[i].cs_n == 1'b0) c++;
    return c;
  endfunction

  initial begin
    logic [31:0] s;
    int          n, tl, th;
    logic [15:0] words[$];

    checks = 0;
    failures = 0;
    rec = 0;
    bus.address    = 2'd0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = '0;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // reset state
    @(negedge clk);
    chk("rst_cs_n", lcd_cs_n, 1'b1);
    chk("rst_wr_n", lcd_wr_n, 1'b1);
    chk("rst_rd_n", lcd_rd_n, 1'b1);
    chk("rst_rs",   lcd_rs,   1'b1);
    chk("rst_data", lcd_data, 16'h0);
    rd(2'd2, s);
    chk("rst_status", s, 32'h4);
    rd(2'd3, s);
    chk("rst_timing", s, 32'h11);
    rd(2'd0, s);
    chk("rd_addr0", s, 32'h0);

    // single command, first-transaction latency
    rec = 1;
    push(1'b0, 16'h002C, 1, 1, 1'b1);
    @(negedge clk);
    chk("lat_idle_cs", lcd_cs_n, 1'b1);
    @(negedge clk);
    chk("lat_setup_cs", lcd_cs_n, 1'b0);
    chk("lat_setup_wr", lcd_wr_n, 1'b1);
    chk("lat_setup_rs", lcd_rs, 1'b0);
    chk("lat_setup_data", lcd_data, 16'h002C);
    @(negedge clk);
    chk("lat_wr_fall", lcd_wr_n, 1'b0);
    wait_idle("single", 50);
    rec = 0;
    chk("single_cs_cycles", cs_low_count(), 5);
    check_strobes("single");

    // back-to-back command + two data words
    rec = 1;
    push(1'b0, 16'h002C, 1, 1, 1'b1);
    push(1'b1, 16'hF800, 1, 1, 1'b1);
    push(1'b1, 16'h07E0, 1, 1, 1'b1);
    wait_idle("b2b", 100);
    rec = 0;
    chk("b2b_cs_cycles", cs_low_count(), 15);
    chk("b2b_cs_falls", cs_falls(), 1);
    check_strobes("b2b");

    // timing change, including a rewrite mid-strobe
    wr(2'd3, 32'h32);
    rd(2'd3, s);
    chk("tim_readback", s, 32'h32);
    rec = 1;
    push(1'b1, 16'h1234, 2, 3, 1'b1);
    wait_wr_low("tim", 50);
    wr(2'd3, 32'h00);
    wait_idle("tim_a", 100);
    push(1'b1, 16'hABCD, 0, 0, 1'b1);
    wait_idle("tim_b", 100);
    rec = 0;
    check_strobes("tim");

    // randomized rounds against the word-order model
    for (int r = 0; r < 4; r++) begin
      tl = $urandom_range(0, 3);
      th = $urandom_range(0, 3);
      wr(2'd3, 32'((th << 4) | tl));
      n = $urandom_range(1, D);
      rec = 1;
      for (int i = 0; i < n; i++) begin
        push(1'($urandom_range(0, 1)), 16'($urandom), tl, th, 1'b1);
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      wait_idle($sformatf("rnd%0d", r), 2000);
      rec = 0;
      rd(2'd2, s);
      chk($sformatf("rnd%0d_status", r), s, 32'h4);
      check_strobes($sformatf("rnd%0d", r));
    end

    // overflow behind a slow strobe
    wr(2'd3, 32'hFF);
    rec = 1;
    push(1'b1, 16'h5A5A, 15, 15, 1'b1);
    n = 0;
    do begin
      rd(2'd2, s);
      n++;
    end while (!(s[0] && s[15:8] == 8'd0) && n < 20);
    chk("ovf_drained_head", {s[15:8], s[0]}, {8'd0, 1'b1});
    words.delete();
    for (int i = 0; i < D + 3; i++) words.push_back(16'($urandom));
    for (int i = 0; i < D + 3; i++)
      push(1'b1, words[i], 15, 15, i < D);
    rd(2'd2, s);
    chk("ovf_status", s, 32'h100B);
    wr(2'd2, 32'h8);
    rd(2'd2, s);
    chk("ovf_cleared", s, 32'h1003);
    wait_idle("ovf", 1500);
    rec = 0;
    check_strobes("ovf");

    // asynchronous reset during WR_LOW
    wr(2'd3, 32'h11);
    push(1'b1, 16'h1111, 1, 1, 1'b0);
    push(1'b1, 16'h2222, 1, 1, 1'b0);
    push(1'b1, 16'h3333, 1, 1, 1'b0);
    wait_wr_low("arst", 50);
    #1;
    reset_n = 1'b0;
    #1;
    chk("arst_wr_n", lcd_wr_n, 1'b1);
    chk("arst_cs_n", lcd_cs_n, 1'b1);
    chk("arst_rs",   lcd_rs,   1'b1);
    chk("arst_data", lcd_data, 16'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    rd(2'd2, s);
    chk("arst_status", s, 32'h4);
    rd(2'd3, s);
    chk("arst_timing", s, 32'h11);
    trace.delete();
    rec = 1;
    repeat (20) @(negedge clk);
    rec = 0;
    chk("arst_no_cs", cs_low_count(), 0);
    check_strobes("arst");

`ifdef ILI_BUS_CTRL_RESET_PIN_EN
    chk("rstpin_reset", lcd_rst_n, 1'b0);
    rd(2'd2, s);
    chk("rstpin_rd0", s[4], 1'b0);
    wr(2'd2, 32'h10);
    @(negedge clk);
    chk("rstpin_set", lcd_rst_n, 1'b1);
    rd(2'd2, s);
    chk("rstpin_rd1", s[4], 1'b1);
`else
    wr(2'd2, 32'h10);
    rd(2'd2, s);
    chk("rstpin_absent", s, 32'h4);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule
